// File: rtl/powlib_pktarb.sv
// Packet-aware round-robin merge of N ready/valid beat streams into one stream,
// tagging each beat with its source channel; output registered through a 2-entry skid.
module powlib_pktarb #(
  parameter int W    = 33,
  parameter int N    = 3,
  parameter int LOCK = 1,
  localparam int IDW = (N > 1) ? $clog2(N) : 1
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N*W-1:0] indata,
  input  logic [N-1:0]   invld,
  output logic [N-1:0]   inrdy,
  output logic [W-1:0]   outdata,
  output logic [IDW-1:0] outid,
  output logic           outvld,
  input  logic           outrdy,
  output logic           dbg_state
);

  // Handshake: a beat moves when valid&ready are both high on a rising edge; a source
  // holds valid and data until then, and outvld/outdata/outid never change while stalled.

  typedef enum logic {S_IDLE, S_BUSY} state_t;

  state_t           r_state, w_state_nxt;
  logic [IDW-1:0]   r_grant, w_grant_nxt;
  logic [IDW-1:0]   r_ptr, w_ptr_nxt;
  logic [1:0]       r_cnt;
  logic [IDW+W-1:0] r_ent0, r_ent1;
  logic [N-1:0]     w_gnt_oh, w_req_other;
  logic [W-1:0]     w_beat;
  logic [IDW+W-1:0] w_ent_new;
  logic             w_push, w_pop, w_end;
  logic [IDW:0]     w_arb_idle, w_arb_busy;

  function automatic logic [IDW-1:0] f_next(input logic [IDW-1:0] g);
    if (int'(g) >= N - 1) return '0;
    return g + IDW'(1);
  endfunction

  // Returns {found, index}: first requester at or after start, scanning upward modulo N.
  function automatic logic [IDW:0] f_arb(input logic [N-1:0] req, input logic [IDW-1:0] start);
    logic [IDW:0]   res;
    logic [2*N-1:0] dbl;
    int             idx;
    res = '0;
    dbl = {req, req} >> start;
    for (int k = N - 1; k >= 0; k--) begin
      if (dbl[k]) begin
        idx = int'(start) + k;
        if (idx >= N) idx = idx - N;
        res = {1'b1, idx[IDW-1:0]};
      end
    end
    return res;
  endfunction

  for (genvar i = 0; i < N; i++) begin : g_ch
    assign w_gnt_oh[i] = (r_grant == IDW'(i));
    assign inrdy[i]    = (r_state == S_BUSY) & w_gnt_oh[i] & (r_cnt != 2'd2);
  end

  assign w_beat      = indata[r_grant*W +: W];
  assign w_ent_new   = {r_grant, w_beat};
  assign w_push      = |(invld & inrdy);
  assign w_pop       = outvld & outrdy;
  assign w_end       = w_push & ((LOCK == 0) | w_beat[W-1]);
  assign w_req_other = invld & ~w_gnt_oh;
  assign w_arb_idle  = f_arb(invld, r_ptr);
  assign w_arb_busy  = f_arb(w_req_other, f_next(r_grant));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_grant <= '0;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_grant <= w_grant_nxt;
      r_ptr   <= w_ptr_nxt;
    end
  end

  // At a grant end another requester takes over in the same cycle, so packets from
  // different channels stream back to back without an arbitration bubble.
  always_comb begin
    w_state_nxt = r_state;
    w_grant_nxt = r_grant;
    w_ptr_nxt   = r_ptr;
    case (r_state)
      S_IDLE: begin
        if (|invld) begin
          w_state_nxt = S_BUSY;
          w_grant_nxt = w_arb_idle[IDW-1:0];
        end
      end
      S_BUSY: begin
        if (w_end) begin
          w_ptr_nxt = f_next(r_grant);
          if (w_arb_busy[IDW]) w_grant_nxt = w_arb_busy[IDW-1:0];
          else                 w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Skid FIFO: r_ent0 is always the head and drives the output directly.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt  <= '0;
      r_ent0 <= '0;
      r_ent1 <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_cnt == 2'd0) r_ent0 <= w_ent_new;
          else               r_ent1 <= w_ent_new;
          r_cnt <= r_cnt + 2'd1;
        end
        2'b01: begin
          r_ent0 <= r_ent1;
          r_cnt  <= r_cnt - 2'd1;
        end
        2'b11: begin
          if (r_cnt == 2'd1) begin
            r_ent0 <= w_ent_new;
          end else begin
            r_ent0 <= r_ent1;
            r_ent1 <= w_ent_new;
          end
        end
        default: ;
      endcase
    end
  end

  assign outvld    = (r_cnt != 2'd0);
  assign outdata   = r_ent0[W-1:0];
  assign outid     = r_ent0[IDW+W-1:W];
  assign dbg_state = (r_state == S_BUSY);

endmodule

// File: tb/tb_powlib_pktarb.sv
// Directed bench for powlib_pktarb: one locked (LOCK=1) and one per-beat (LOCK=0)
// instance share the inputs; sel picks whose outputs the scenario observes.
module tb_powlib_pktarb;
  localparam int W   = 33;
  localparam int N   = 3;
  localparam int IDW = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic [N*W-1:0] indata;
  logic [N-1:0]   invld;
  logic           outrdy;
  logic [N-1:0]   inrdy_a, inrdy_b;
  logic [W-1:0]   outdata_a, outdata_b;
  logic [IDW-1:0] outid_a, outid_b;
  logic           outvld_a, outvld_b, dbg_a, dbg_b;

  logic           sel;
  logic [N-1:0]   cur_inrdy;
  logic [W-1:0]   cur_outdata;
  logic [IDW-1:0] cur_outid;
  logic           cur_outvld, cur_dbg;

  logic [W-1:0]     src_q [N][$];
  logic [IDW+W-1:0] exp_q[$];
  logic [IDW+W-1:0] got_q[$];
  logic [N-1:0]     acc, hold;
  logic             tb_rdy;
  int               checks, failures, cyc, n_acc;

  assign cur_inrdy   = sel ? inrdy_b   : inrdy_a;
  assign cur_outdata = sel ? outdata_b : outdata_a;
  assign cur_outid   = sel ? outid_b   : outid_a;
  assign cur_outvld  = sel ? outvld_b  : outvld_a;
  assign cur_dbg     = sel ? dbg_b     : dbg_a;

  powlib_pktarb #(.W(W), .N(N), .LOCK(1)) dut_lock (
    .clk(clk), .rst(rst), .indata(indata), .invld(invld), .inrdy(inrdy_a),
    .outdata(outdata_a), .outid(outid_a), .outvld(outvld_a), .outrdy(outrdy),
    .dbg_state(dbg_a)
  );

  powlib_pktarb #(.W(W), .N(N), .LOCK(0)) dut_beat (
    .clk(clk), .rst(rst), .indata(indata), .invld(invld), .inrdy(inrdy_b),
    .outdata(outdata_b), .outid(outid_b), .outvld(outvld_b), .outrdy(outrdy),
    .dbg_state(dbg_b)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] mk(input int c, input int k, input logic eop);
    return {eop, 32'(c * 256 + k + 1)};
  endfunction

  function automatic logic [IDW+W-1:0] ent(input int c, input logic [W-1:0] b);
    return {IDW'(c), b};
  endfunction

  // One cycle of sources and sink: retire last cycle's accepts, present queue heads,
  // then note which handshakes will complete on the coming rising edge.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int c = 0; c < N; c++) begin
      if (acc[c]) begin
        void'(src_q[c].pop_front());
        n_acc++;
      end
    end
    for (int c = 0; c < N; c++) begin
      if (src_q[c].size() > 0 && !hold[c]) begin
        invld[c] = 1'b1;
        indata[c*W +: W] = src_q[c][0];
      end else begin
        invld[c] = 1'b0;
      end
    end
    outrdy = tb_rdy;
    acc = invld & cur_inrdy;
    if (cur_outvld && outrdy) got_q.push_back({cur_outid, cur_outdata});
  endtask

  task automatic do_reset();
    rst = 1'b1;
    acc = '0;
    hold = '0;
    invld = '0;
    tb_rdy = 1'b0;
    outrdy = 1'b0;
    for (int c = 0; c < N; c++) src_q[c].delete();
    exp_q.delete();
    got_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    sel = 1'b0;
    rst = 1'b1;
    acc = '0;
    hold = '0;
    tb_rdy = 1'b0;
    outrdy = 1'b0;
    for (int c = 0; c < N; c++) begin
      src_q[c].delete();
      src_q[c].push_back(mk(c, 0, 1'b1));
      indata[c*W +: W] = mk(c, 0, 1'b1);
    end
    invld = 3'b111;
    @(negedge clk);
    checks++;
    if (cur_outvld !== 1'b0) begin failures++; $display("FAIL rst_outvld: got %b want 0", cur_outvld); end
    checks++;
    if (cur_inrdy !== 3'b000) begin failures++; $display("FAIL rst_inrdy: got %b want 000", cur_inrdy); end
    checks++;
    if (cur_outdata !== '0) begin failures++; $display("FAIL rst_outdata: got %h want 0", cur_outdata); end
    checks++;
    if (cur_outid !== '0) begin failures++; $display("FAIL rst_outid: got %0d want 0", cur_outid); end
    @(negedge clk);
    checks++;
    if (cur_inrdy !== 3'b000 || cur_outvld !== 1'b0) begin
      failures++;
      $display("FAIL rst_held: got inrdy=%b outvld=%b want 000/0", cur_inrdy, cur_outvld);
    end
    rst = 1'b0;
    step();
    checks++;
    if (cur_inrdy !== 3'b001) begin failures++; $display("FAIL rst_first_grant: got inrdy=%b want 001", cur_inrdy); end
    checks++;
    if (cur_dbg !== 1'b1) begin failures++; $display("FAIL rst_busy: got state=%b want 1", cur_dbg); end
  endtask

  task automatic test_round_robin();
    int first, last;
    sel = 1'b0;
    do_reset();
    for (int c = 0; c < N; c++) begin
      src_q[c].push_back(mk(c, 0, 1'b0));
      src_q[c].push_back(mk(c, 1, 1'b1));
      exp_q.push_back(ent(c, mk(c, 0, 1'b0)));
      exp_q.push_back(ent(c, mk(c, 1, 1'b1)));
    end
    tb_rdy = 1'b1;
    first = -1;
    last = -1;
    for (int t = 0; t < 40 && last < 0; t++) begin
      step();
      if (first < 0 && cur_outvld) first = cyc;
      if (got_q.size() == 6) last = cyc;
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_q.size()) begin
        failures++;
        $display("FAIL rr_beat%0d: got nothing want %h", i, exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL rr_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (first < 0 || last < 0 || (last - first + 1) > 7) begin
      failures++;
      $display("FAIL rr_throughput: got first=%0d last=%0d want 6 beats within 7 cycles", first, last);
    end
  endtask

  task automatic test_packet_lock();
    bit seen;
    sel = 1'b0;
    do_reset();
    src_q[1].push_back(mk(1, 0, 1'b0));
    src_q[1].push_back(mk(1, 1, 1'b1));
    src_q[0].push_back(mk(0, 5, 1'b1));
    exp_q.push_back(ent(1, mk(1, 0, 1'b0)));
    exp_q.push_back(ent(1, mk(1, 1, 1'b1)));
    exp_q.push_back(ent(0, mk(0, 5, 1'b1)));
    hold = 3'b001;
    tb_rdy = 1'b1;
    seen = 1'b0;
    for (int t = 0; t < 10 && !seen; t++) begin
      step();
      seen = acc[1];
    end
    checks++;
    if (!seen) begin failures++; $display("FAIL lock_first_accept: got no accept want ch1 beat 0 accepted"); end
    hold = 3'b010;
    for (int t = 0; t < 5; t++) begin
      step();
      checks++;
      if (cur_inrdy !== 3'b010) begin
        failures++;
        $display("FAIL lock_hold%0d: got inrdy=%b want 010", t, cur_inrdy);
      end
    end
    hold = 3'b000;
    for (int t = 0; t < 20 && got_q.size() < 3; t++) step();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size()) begin
        failures++;
        $display("FAIL lock_beat%0d: got nothing want %h", i, exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL lock_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    sel = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      src_q[2].push_back(mk(2, k, k == 3));
      exp_q.push_back(ent(2, mk(2, k, k == 3)));
    end
    tb_rdy = 1'b0;
    n_acc = 0;
    repeat (10) step();
    checks++;
    if (n_acc !== 2) begin failures++; $display("FAIL bp_accepted: got %0d want 2", n_acc); end
    checks++;
    if (cur_inrdy !== 3'b000) begin failures++; $display("FAIL bp_inrdy: got %b want 000", cur_inrdy); end
    checks++;
    if (cur_outvld !== 1'b1 || cur_outdata !== mk(2, 0, 1'b0) || cur_outid !== 2'd2) begin
      failures++;
      $display("FAIL bp_stall_out: got vld=%b id=%0d data=%h want 1/2/%h",
               cur_outvld, cur_outid, cur_outdata, mk(2, 0, 1'b0));
    end
    tb_rdy = 1'b1;
    for (int t = 0; t < 20 && got_q.size() < 4; t++) step();
    repeat (4) step();
    checks++;
    if (got_q.size() !== 4) begin failures++; $display("FAIL bp_count: got %0d beats want 4", got_q.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (i >= got_q.size()) begin
        failures++;
        $display("FAIL bp_beat%0d: got nothing want %h", i, exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL bp_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  task automatic test_lock0();
    sel = 1'b1;
    do_reset();
    for (int k = 0; k < 4; k++) begin
      src_q[0].push_back(mk(0, k, k == 3));
      src_q[2].push_back(mk(2, k, k == 3));
    end
    for (int k = 0; k < 3; k++) begin
      exp_q.push_back(ent(0, mk(0, k, 1'b0)));
      exp_q.push_back(ent(2, mk(2, k, 1'b0)));
    end
    tb_rdy = 1'b1;
    for (int t = 0; t < 40 && got_q.size() < 6; t++) step();
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (i >= got_q.size()) begin
        failures++;
        $display("FAIL l0_beat%0d: got nothing want %h", i, exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL l0_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
    sel = 1'b0;
  endtask

  task automatic test_reset_mid_packet();
    sel = 1'b0;
    do_reset();
    for (int k = 0; k < 4; k++) src_q[0].push_back(mk(0, k, k == 3));
    tb_rdy = 1'b0;
    repeat (6) step();
    checks++;
    if (cur_outvld !== 1'b1 || cur_inrdy !== 3'b000) begin
      failures++;
      $display("FAIL mid_full: got vld=%b inrdy=%b want 1/000", cur_outvld, cur_inrdy);
    end
    #2;
    rst = 1'b1;
    acc = '0;
    #1;
    checks++;
    if (cur_outvld !== 1'b0 || cur_inrdy !== 3'b000 || cur_outdata !== '0) begin
      failures++;
      $display("FAIL mid_async: got vld=%b inrdy=%b data=%h want 0/000/0", cur_outvld, cur_inrdy, cur_outdata);
    end
    for (int c = 0; c < N; c++) src_q[c].delete();
    got_q.delete();
    invld = '0;
    @(negedge clk);
    rst = 1'b0;
    src_q[1].push_back(mk(1, 8, 1'b0));
    src_q[1].push_back(mk(1, 9, 1'b1));
    src_q[0].push_back(mk(0, 7, 1'b1));
    exp_q.push_back(ent(0, mk(0, 7, 1'b1)));
    exp_q.push_back(ent(1, mk(1, 8, 1'b0)));
    exp_q.push_back(ent(1, mk(1, 9, 1'b1)));
    tb_rdy = 1'b1;
    repeat (15) step();
    checks++;
    if (got_q.size() !== 3) begin failures++; $display("FAIL mid_count: got %0d beats want 3", got_q.size()); end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_q.size()) begin
        failures++;
        $display("FAIL mid_beat%0d: got nothing want %h", i, exp_q[i]);
      end else if (got_q[i] !== exp_q[i]) begin
        failures++;
        $display("FAIL mid_beat%0d: got %h want %h", i, got_q[i], exp_q[i]);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    cyc = 0;
    n_acc = 0;
    sel = 1'b0;
    indata = '0;
    invld = '0;
    hold = '0;
    acc = '0;
    tb_rdy = 1'b0;
    outrdy = 1'b0;
    rst = 1'b1;
    test_reset();
    test_round_robin();
    test_packet_lock();
    test_backpressure();
    test_lock0();
    test_reset_mid_packet();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
